// File: rtl/latch_sr_drive_sequencer_if.sv
// Command-side handshake between lab control logic and the SR latch drive sequencer.
// The master issues request/command; the slave answers with ready/done/error/stored.
interface latch_sr_drive_sequencer_if;
  logic       request;
  logic [1:0] command;
  logic       ready;
  logic       done;
  logic       error;
  logic       stored;

  modport master (output request, output command,
                  input ready, input done, input error, input stored);
  modport slave  (input request, input command,
                  output ready, output done, output error, output stored);
endinterface

// File: rtl/latch_sr_drive_sequencer.sv
// Drives a gated NOR SR latch through setup -> enable pulse -> hold, then checks q/q_.
// Optional macro LATCH_SYNC_EN adds a 2-flop read-back synchronizer and a SYNC wait state.
module latch_sr_drive_sequencer #(
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 2,
  parameter int HOLD_CYCLES  = 1,
  parameter int CNT_WIDTH    = 4
) (
  input  logic                            clock,
  input  logic                            reset_,
  latch_sr_drive_sequencer_if.slave       cmd_bus,
  output logic                            latch_enable,
  output logic                            latch_set,
  output logic                            latch_reset,
  input  logic                            latch_q,
  input  logic                            latch_q_
);

  localparam int SETUP_EFF = (SETUP_CYCLES < 1) ? 1 : SETUP_CYCLES;
  localparam int PULSE_EFF = (PULSE_CYCLES < 1) ? 1 : PULSE_CYCLES;
  localparam int HOLD_EFF  = (HOLD_CYCLES  < 1) ? 1 : HOLD_CYCLES;
  localparam logic [CNT_WIDTH-1:0] SETUP_LOAD = CNT_WIDTH'(SETUP_EFF - 1);
  localparam logic [CNT_WIDTH-1:0] PULSE_LOAD = CNT_WIDTH'(PULSE_EFF - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LOAD  = CNT_WIDTH'(HOLD_EFF - 1);

`ifdef LATCH_SYNC_EN
  localparam logic [CNT_WIDTH-1:0] SYNC_LOAD = CNT_WIDTH'(1);
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, SYNC, CHECK} state_t;
`else
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, CHECK} state_t;
`endif

  state_t               state, next_state;
  logic [CNT_WIDTH-1:0] cnt, next_cnt;
  logic [1:0]           cmd_r, next_cmd;
  logic                 next_ready, next_done, next_error, next_stored;
  logic                 next_enable, next_set, next_reset;
  logic                 drive_phase, check_ok;
  logic                 q_sample, qn_sample;

`ifdef LATCH_SYNC_EN
  logic [1:0] q_sync, qn_sync;

  always_ff @(posedge clock) begin
    if (!reset_) begin
      q_sync  <= 2'b00;
      qn_sync <= 2'b00;
    end else begin
      q_sync  <= {q_sync[0], latch_q};
      qn_sync <= {qn_sync[0], latch_q_};
    end
  end

  assign q_sample  = q_sync[1];
  assign qn_sample = qn_sync[1];
`else
  assign q_sample  = latch_q;
  assign qn_sample = latch_q_;
`endif

  // All outputs are registered from next-state values so the latch pins never glitch.
  always_ff @(posedge clock) begin
    if (!reset_) begin
      state          <= IDLE;
      cnt            <= '0;
      cmd_r          <= 2'b00;
      cmd_bus.ready  <= 1'b0;
      cmd_bus.done   <= 1'b0;
      cmd_bus.error  <= 1'b0;
      cmd_bus.stored <= 1'b0;
      latch_enable   <= 1'b0;
      latch_set      <= 1'b0;
      latch_reset    <= 1'b0;
    end else begin
      state          <= next_state;
      cnt            <= next_cnt;
      cmd_r          <= next_cmd;
      cmd_bus.ready  <= next_ready;
      cmd_bus.done   <= next_done;
      cmd_bus.error  <= next_error;
      cmd_bus.stored <= next_stored;
      latch_enable   <= next_enable;
      latch_set      <= next_set;
      latch_reset    <= next_reset;
    end
  end

  always_comb begin
    next_state  = state;
    next_cnt    = cnt;
    next_cmd    = cmd_r;
    next_error  = cmd_bus.error;
    next_stored = cmd_bus.stored;
    next_done   = 1'b0;
    check_ok    = 1'b0;

    case (state)
      IDLE: begin
        if (cmd_bus.request && cmd_bus.ready) begin
          next_cmd   = cmd_bus.command;
          next_error = 1'b0;
          if (cmd_bus.command == 2'b01 || cmd_bus.command == 2'b10) begin
            next_state = SETUP;
            next_cnt   = SETUP_LOAD;
          end else begin
`ifdef LATCH_SYNC_EN
            next_state = SYNC;
            next_cnt   = SYNC_LOAD;
`else
            next_state = CHECK;
`endif
          end
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          next_state = PULSE;
          next_cnt   = PULSE_LOAD;
        end else begin
          next_cnt = cnt - 1'b1;
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          next_state = HOLD;
          next_cnt   = HOLD_LOAD;
        end else begin
          next_cnt = cnt - 1'b1;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
`ifdef LATCH_SYNC_EN
          next_state = SYNC;
          next_cnt   = SYNC_LOAD;
`else
          next_state = CHECK;
`endif
        end else begin
          next_cnt = cnt - 1'b1;
        end
      end
`ifdef LATCH_SYNC_EN
      SYNC: begin
        if (cnt == '0) begin
          next_state = CHECK;
        end else begin
          next_cnt = cnt - 1'b1;
        end
      end
`endif
      CHECK: begin
        next_state = IDLE;
        next_done  = 1'b1;
        // A read only needs q/q_ complementary; set/reset also need q to match.
        case (cmd_r)
          2'b00:   check_ok = (q_sample != qn_sample);
          2'b01:   check_ok = (q_sample != qn_sample) && q_sample;
          2'b10:   check_ok = (q_sample != qn_sample) && !q_sample;
          default: check_ok = 1'b0;
        endcase
        if (check_ok) begin
          next_stored = q_sample;
        end else begin
          next_error = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase

    next_ready  = (next_state == IDLE);
    drive_phase = (next_state == SETUP) || (next_state == PULSE) || (next_state == HOLD);
    next_set    = drive_phase && next_cmd[0];
    next_reset  = drive_phase && next_cmd[1];
    next_enable = (next_state == PULSE);
  end

endmodule

// File: tb/tb_latch_sr_drive_sequencer.sv
// Scoreboard bench for latch_sr_drive_sequencer: drives a behavioural NOR SR latch and
// predicts each command's outcome and timing from the command rules (LATCH_SYNC_EN aware).
module tb_latch_sr_drive_sequencer;

  localparam int S = 1;
  localparam int P = 2;
  localparam int H = 1;
`ifdef LATCH_SYNC_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif

  typedef struct packed {
    logic [1:0] cmd;
    int         k;
    int         done_c;
    logic       err;
    logic       st;
  } txn_t;

  logic clock = 1'b0;
  logic reset_ = 1'b0;
  logic latch_enable, latch_set, latch_reset, latch_q, latch_q_;
  logic latch_state = 1'b0;
  logic stuck = 1'b0;

  txn_t sb[$];
  txn_t mon_t;
  int   cyc = 0;
  logic rst_at_edge = 1'b0;
  int   compared = 0;
  int   mismatched = 0;
  logic model_lq = 1'b0;
  logic model_stored = 1'b0;
  logic [2:0] exp_drive;
  logic exp_done_now;

  latch_sr_drive_sequencer_if bus ();

  latch_sr_drive_sequencer dut (
    .clock        (clock),
    .reset_       (reset_),
    .cmd_bus      (bus),
    .latch_enable (latch_enable),
    .latch_set    (latch_set),
    .latch_reset  (latch_reset),
    .latch_q      (latch_q),
    .latch_q_     (latch_q_)
  );

  always #5 clock = ~clock;

  // Gated NOR latch; 'stuck' pins q at 0 to model a broken gate.
  always @(latch_enable or latch_set or latch_reset) begin
    if (latch_enable && latch_set) latch_state = 1'b1;
    else if (latch_enable && latch_reset) latch_state = 1'b0;
  end
  assign latch_q  = stuck ? 1'b0 : latch_state;
  assign latch_q_ = ~latch_state;

  always @(posedge clock) begin
    cyc         <= cyc + 1;
    rst_at_edge <= reset_;
  end

  task checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  // Monitor: per-cycle pin expectations plus scoreboard pop whenever done is presented.
  always @(negedge clock) begin
    if (cyc > 0) begin
      if (!rst_at_edge) begin
        checkOutput("reset_state", 32'({bus.ready, bus.done, bus.error, bus.stored,
                                         latch_enable, latch_set, latch_reset}), 32'd0);
      end else begin
        exp_drive    = 3'b000;
        exp_done_now = 1'b0;
        if (sb.size() > 0) begin
          mon_t = sb[0];
          if (mon_t.cmd == 2'b01 || mon_t.cmd == 2'b10) begin
            if (cyc >= mon_t.k && cyc <= mon_t.k + S + P + H - 1)
              exp_drive[1:0] = {mon_t.cmd[0], mon_t.cmd[1]};
            if (cyc >= mon_t.k + S && cyc <= mon_t.k + S + P - 1)
              exp_drive[2] = 1'b1;
          end
          exp_done_now = (cyc == mon_t.done_c);
        end
        checkOutput("latch_drive", 32'({latch_enable, latch_set, latch_reset}), 32'(exp_drive));
        checkOutput("set_reset_excl", 32'(latch_set & latch_reset), 32'd0);
        checkOutput("ready", 32'(bus.ready), 32'((sb.size() == 0) || exp_done_now));
        checkOutput("done", 32'(bus.done), 32'(exp_done_now));
        if (exp_done_now && bus.done) begin
          checkOutput("error", 32'(bus.error), 32'(mon_t.err));
          checkOutput("stored", 32'(bus.stored), 32'(mon_t.st));
          void'(sb.pop_front());
        end else if (sb.size() > 0 && cyc >= mon_t.done_c) begin
          void'(sb.pop_front());
        end
      end
    end
  end

  task applyStimulus(input logic [1:0] cmd, input logic use_stuck, input logic hold_req);
    int   waited;
    txn_t t;
    logic lq_after, obs_q, obs_qn, ok;
    waited = 0;
    @(negedge clock);
    while (!bus.ready && waited < 100) begin
      bus.request = hold_req;
      bus.command = 2'($urandom);
      @(negedge clock);
      waited++;
    end
    if (!bus.ready) begin
      checkOutput("ready_timeout", 32'(bus.ready), 32'd1);
      return;
    end
    stuck       = use_stuck;
    bus.request = 1'b1;
    bus.command = cmd;
    lq_after = (cmd == 2'b01) ? 1'b1 : (cmd == 2'b10) ? 1'b0 : model_lq;
    obs_q    = use_stuck ? 1'b0 : lq_after;
    obs_qn   = ~lq_after;
    ok       = (obs_q != obs_qn) && (cmd == 2'b00 || obs_q == (cmd == 2'b01)) && (cmd != 2'b11);
    model_lq = lq_after;
    if (ok) model_stored = obs_q;
    t.cmd = cmd;
    t.err = ~ok;
    t.st  = model_stored;
    @(posedge clock);
    #1;
    t.k      = cyc;
    t.done_c = cyc + (((cmd == 2'b01) || (cmd == 2'b10)) ? (S + P + H + 2) : 2) + EXTRA - 1;
    sb.push_back(t);
    @(negedge clock);
    bus.request = hold_req;
    bus.command = 2'($urandom);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   waited;
    logic prev_hold, hold, use_stuck;
    logic [1:0] cmd;
    bus.request = 1'b0;
    bus.command = 2'b00;
    repeat (2) @(negedge clock);
    #2 reset_ = 1'b1;

    applyStimulus(2'b01, 1'b0, 1'b0);
    applyStimulus(2'b10, 1'b0, 1'b0);
    applyStimulus(2'b11, 1'b0, 1'b0);
    applyStimulus(2'b00, 1'b0, 1'b0);
    applyStimulus(2'b01, 1'b1, 1'b0);
    applyStimulus(2'b00, 1'b0, 1'b0);

    // Abort a reset command mid-pulse after poking request while busy.
    applyStimulus(2'b10, 1'b0, 1'b0);
    @(negedge clock);
    bus.request = 1'b1;
    bus.command = 2'b01;
    @(negedge clock);
    bus.request = 1'b0;
    #2 reset_ = 1'b0;
    sb.delete();
    model_stored = 1'b0;
    model_lq     = 1'b0;
    @(negedge clock);
    #2 reset_ = 1'b1;
    applyStimulus(2'b00, 1'b0, 1'b0);

    prev_hold = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cmd       = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      use_stuck = ($urandom_range(0, 5) == 0);
      hold      = 1'($urandom_range(0, 1));
      if (!prev_hold) repeat ($urandom_range(0, 2)) @(negedge clock);
      applyStimulus(cmd, use_stuck, hold);
      prev_hold = hold;
    end
    bus.request = 1'b0;

    waited = 0;
    while (sb.size() > 0 && waited < 100) begin
      @(negedge clock);
      waited++;
    end
    checkOutput("drain", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
